memory_cycle: RTL and testbench
===============================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, maximum wait cycles for dmem_ready before a bus access aborts; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 RegWriteM  input  1  register-write enable from the EX/MEM register.
REQ-005 MemWriteM  input  1  store request.
REQ-006 ResultSrcM  input  2  writeback source select; 2'b01 denotes a load.
REQ-007 RD_M  input  5  destination register index.
REQ-008 PCPlus4M, WriteDataM, ALU_ResultM  input  32 each  link value, store data, and ALU result or effective address.
REQ-009 dmem_req  output  1  data-memory request.
REQ-010 dmem_we  output  1  request is a write.
REQ-011 dmem_addr  output  32  word-aligned address.
REQ-012 dmem_wdata  output  32  store data.
REQ-013 dmem_ready  input  1  memory accepts or completes the current request.
REQ-014 dmem_rdata  input  32  load data, valid while dmem_ready=1.
REQ-015 StallM  output  1  holds IF/ID/EX stages and the EX/MEM register.
REQ-016 RegWriteW  output  1  registered writeback outputs.
REQ-017 ResultSrcW  output  2  registered writeback outputs.
REQ-018 RD_W  output  5  registered writeback outputs.
REQ-019 PCPlus4W, ALU_ResultW, ReadDataW  output  32 each  registered writeback outputs.
REQ-020 bus_err, misalign_err  output  1 each  sticky error flags.

Function
REQ-021 Access condition: access = MemWriteM | (ResultSrcM==2'b01).
REQ-022 Misaligned access: an access with ALU_ResultM[1:0]!=0 issues no request, sets misalign_err, and loads a bubble into MEM/WB (RegWriteW=0, all other W outputs 0).
REQ-023 Request outputs: dmem_addr={ALU_ResultM[31:2],2'b00}; dmem_wdata=WriteDataM; dmem_we=MemWriteM.
REQ-024 FSM state IDLE: for an aligned access, dmem_req=1 combinationally in the same cycle.
REQ-025 IDLE, dmem_ready=1 in the same cycle: zero-wait completion, no stall, state stays IDLE.
REQ-026 IDLE, dmem_ready=0: StallM=1, next state WAIT, wait counter cleared to 1.
REQ-027 FSM state WAIT: dmem_req is held at 1; address, data and we are unchanged, because upstream holds its inputs while StallM=1.
REQ-028 WAIT, dmem_ready=1: completion, StallM=0, next state IDLE.
REQ-029 WAIT, dmem_ready=0: counter increments and StallM=1.
REQ-030 WAIT timeout: when the counter reaches TIMEOUT_CYCLES with dmem_ready=0, the access aborts. dmem_req=0 that cycle, StallM=0, bus_err=1 (sticky), and MEM/WB loads a bubble. Next state IDLE.
REQ-031 StallM = dmem_req & ~dmem_ready & ~timeout_hit.
REQ-032 MEM/WB register: updates every clock. While StallM=1 it captures a bubble (RegWriteW=0, ResultSrcW=0, RD_W=0, data outputs 0).
REQ-033 MEM/WB register, otherwise: captures RegWriteM, ResultSrcM, RD_M, PCPlus4M and ALU_ResultM. ReadDataW captures dmem_rdata on load completion and 0 in all other cases.
REQ-034 Non-access instructions: pass through MEM/WB in one cycle with no stall.
REQ-035 Latency: zero-wait access takes 1 cycle to W outputs; N-wait access takes N+1 cycles.
REQ-036 Stores: a completed store writes ReadDataW=0 and passes RegWriteW through unchanged.
REQ-037 Error-flag precedence: errors take priority over completion; misalign_err and bus_err never clear except on reset.

Reset
REQ-038 Asserting rst asynchronously forces: state IDLE, counter 0, all W outputs 0, bus_err=0, misalign_err=0.
REQ-039 While rst=1: dmem_req=0 and StallM=0, regardless of inputs.
REQ-040 rst asserted in WAIT: the in-flight request is dropped with no writeback; after release the block is in IDLE.

Verification
REQ-041 Zero-wait load: ResultSrcM=01, ALU_ResultM=0x100, dmem_ready=1, dmem_rdata=0xDEADBEEF -> dmem_addr=0x100, StallM=0, next cycle ReadDataW=0xDEADBEEF, RegWriteW=RegWriteM.
REQ-042 Store, 3 wait cycles: MemWriteM=1, ALU_ResultM=0x2004, WriteDataM=0x55 -> dmem_we=1, StallM=1 for 3 cycles, bubbles on W, completes on 4th cycle, bus_err=0.
REQ-043 Timeout, TIMEOUT_CYCLES=4, dmem_ready held 0 -> StallM high 4 cycles, then drops, bus_err=1, RegWriteW=0; next access proceeds normally.
REQ-044 Misaligned load at 0x103 -> dmem_req never asserts, misalign_err=1, RegWriteW=0 next cycle, no stall.
REQ-045 Non-memory op (ResultSrcM=00, RegWriteM=1, RD_M=5, ALU_ResultM=7) -> next cycle RD_W=5, ALU_ResultW=7, ReadDataW=0.
REQ-046 rst pulse mid-WAIT -> outputs and flags zero immediately, state IDLE, dmem_req=0.

Source files
------------

// File: rtl/memory_cycle.sv
// MEM stage of a 5-stage pipeline: drives the data-memory request, stalls the
// upstream stages while the memory is not ready, and registers MEM/WB.
module memory_cycle #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        bus_err,
  output logic        misalign_err,
  output logic        dbg_state_o
);

  // Handshake: dmem_req stays high from issue until the cycle dmem_ready=1
  // (completion) or the wait counter expires (abort). Address, data and we
  // are stable for the whole request because StallM freezes the EX/MEM inputs.

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        is_load;
  logic        access;
  logic        aligned;
  logic        complete;
  logic        timeout_hit;
  logic        misalign_hit;
  logic        bubble;

  logic        reg_write_q;
  logic [1:0]  result_src_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_plus4_q;
  logic [31:0] alu_result_q;
  logic [31:0] read_data_q;
  logic        bus_err_q;
  logic        misalign_err_q;

  assign is_load = (ResultSrcM == 2'b01);
  assign access  = MemWriteM | is_load;
  assign aligned = (ALU_ResultM[1:0] == 2'b00);

  assign dmem_addr  = {ALU_ResultM[31:2], 2'b00};
  assign dmem_wdata = WriteDataM;
  assign dmem_we    = MemWriteM;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req     = 1'b0;
    complete     = 1'b0;
    timeout_hit  = 1'b0;
    misalign_hit = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (access) begin
            if (!aligned) begin
              misalign_hit = 1'b1;
            end else begin
              dmem_req = 1'b1;
              if (dmem_ready) begin
                complete = 1'b1;
              end else begin
                state_d = S_WAIT;
                cnt_d   = 8'd1;
              end
            end
          end
        end
        S_WAIT: begin
          if (!dmem_ready && (cnt_q >= TMO)) begin
            // Abort: drop the request so the pipeline can move on.
            timeout_hit = 1'b1;
            state_d     = S_IDLE;
            cnt_d       = 8'd0;
          end else begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
              complete = 1'b1;
              state_d  = S_IDLE;
              cnt_d    = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  assign StallM = dmem_req & ~dmem_ready & ~timeout_hit;
  assign bubble = StallM | misalign_hit | timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      pc_plus4_q   <= 32'd0;
      alu_result_q <= 32'd0;
      read_data_q  <= 32'd0;
    end else if (bubble) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      rd_q         <= 5'd0;
      pc_plus4_q   <= 32'd0;
      alu_result_q <= 32'd0;
      read_data_q  <= 32'd0;
    end else begin
      reg_write_q  <= RegWriteM;
      result_src_q <= ResultSrcM;
      rd_q         <= RD_M;
      pc_plus4_q   <= PCPlus4M;
      alu_result_q <= ALU_ResultM;
      read_data_q  <= (complete && is_load) ? dmem_rdata : 32'd0;
    end
  end

  // Error flags are sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err_q      <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      if (timeout_hit)  bus_err_q      <= 1'b1;
      if (misalign_hit) misalign_err_q <= 1'b1;
    end
  end

  assign RegWriteW    = reg_write_q;
  assign ResultSrcW   = result_src_q;
  assign RD_W         = rd_q;
  assign PCPlus4W     = pc_plus4_q;
  assign ALU_ResultW  = alu_result_q;
  assign ReadDataW    = read_data_q;
  assign bus_err      = bus_err_q;
  assign misalign_err = misalign_err_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle with TIMEOUT_CYCLES=4.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        StallM, RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        bus_err, misalign_err, dbg_state_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  memory_cycle #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
    .ReadDataW(ReadDataW), .bus_err(bus_err), .misalign_err(misalign_err),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    RegWriteM   = 1'b0;
    MemWriteM   = 1'b0;
    ResultSrcM  = 2'b00;
    RD_M        = 5'd0;
    PCPlus4M    = 32'd0;
    WriteDataM  = 32'd0;
    ALU_ResultM = 32'd0;
    dmem_ready  = 1'b0;
    dmem_rdata  = 32'd0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] rd,
                            input logic ready, input logic [31:0] rdata);
    RegWriteM   = 1'b1;
    MemWriteM   = 1'b0;
    ResultSrcM  = 2'b01;
    RD_M        = rd;
    PCPlus4M    = 32'h0000_0040;
    WriteDataM  = 32'h0;
    ALU_ResultM = addr;
    dmem_ready  = ready;
    dmem_rdata  = rdata;
  endtask

  task automatic test_reset();
    drive_load(32'h100, 5'd3, 1'b1, 32'hAAAA_5555);
    rst = 1'b1;
    #3;
    total_cnt++; if (dmem_req !== 1'b0) $display("FAIL reset_req got %b exp 0", dmem_req); else pass_cnt++;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL reset_stall got %b exp 0", StallM); else pass_cnt++;
    tick();
    total_cnt++; if (RegWriteW !== 1'b0 || RD_W !== 5'd0 || ReadDataW !== 32'd0 || ALU_ResultW !== 32'd0)
      $display("FAIL reset_w got rw=%b rd=%0d rdata=%h alu=%h exp all 0", RegWriteW, RD_W, ReadDataW, ALU_ResultW); else pass_cnt++;
    total_cnt++; if (bus_err !== 1'b0 || misalign_err !== 1'b0)
      $display("FAIL reset_flags got bus=%b mis=%b exp 0 0", bus_err, misalign_err); else pass_cnt++;
    total_cnt++; if (dbg_state_o !== 1'b0) $display("FAIL reset_state got %b exp 0", dbg_state_o); else pass_cnt++;
    drive_idle();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_load();
    drive_load(32'h100, 5'd3, 1'b1, 32'hDEAD_BEEF);
    #1;
    total_cnt++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100)
      $display("FAIL zw_req got req=%b we=%b addr=%h exp 1 0 00000100", dmem_req, dmem_we, dmem_addr); else pass_cnt++;
    total_cnt++; if (StallM !== 1'b0) $display("FAIL zw_stall got %b exp 0", StallM); else pass_cnt++;
    tick();
    total_cnt++; if (ReadDataW !== 32'hDEAD_BEEF || RegWriteW !== 1'b1 || RD_W !== 5'd3 || ResultSrcW !== 2'b01 || ALU_ResultW !== 32'h100 || PCPlus4W !== 32'h40)
      $display("FAIL zw_w got rdata=%h rw=%b rd=%0d src=%b alu=%h pc4=%h exp deadbeef 1 3 01 00000100 00000040",
               ReadDataW, RegWriteW, RD_W, ResultSrcW, ALU_ResultW, PCPlus4W); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_store_wait();
    RegWriteM = 1'b1; MemWriteM = 1'b1; ResultSrcM = 2'b00; RD_M = 5'd9;
    PCPlus4M = 32'h80; WriteDataM = 32'h55; ALU_ResultM = 32'h2004;
    dmem_ready = 1'b0; dmem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++; if (StallM !== 1'b1 || dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h55 || dmem_addr !== 32'h2004)
        $display("FAIL st_wait%0d got stall=%b req=%b we=%b wd=%h addr=%h exp 1 1 1 00000055 00002004",
                 i, StallM, dmem_req, dmem_we, dmem_wdata, dmem_addr); else pass_cnt++;
      tick();
      total_cnt++; if (RegWriteW !== 1'b0 || ALU_ResultW !== 32'd0 || RD_W !== 5'd0)
        $display("FAIL st_bubble%0d got rw=%b alu=%h rd=%0d exp 0 0 0", i, RegWriteW, ALU_ResultW, RD_W); else pass_cnt++;
    end
    dmem_ready = 1'b1;
    #1;
    total_cnt++; if (StallM !== 1'b0 || dmem_req !== 1'b1)
      $display("FAIL st_done_cyc got stall=%b req=%b exp 0 1", StallM, dmem_req); else pass_cnt++;
    tick();
    total_cnt++; if (RegWriteW !== 1'b1 || ALU_ResultW !== 32'h2004 || ReadDataW !== 32'd0 || RD_W !== 5'd9)
      $display("FAIL st_w got rw=%b alu=%h rdata=%h rd=%0d exp 1 00002004 0 9", RegWriteW, ALU_ResultW, ReadDataW, RD_W); else pass_cnt++;
    total_cnt++; if (bus_err !== 1'b0 || dbg_state_o !== 1'b0)
      $display("FAIL st_after got bus=%b state=%b exp 0 0", bus_err, dbg_state_o); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_non_mem();
    RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; RD_M = 5'd5;
    PCPlus4M = 32'h1C; ALU_ResultM = 32'd7; dmem_ready = 1'b0; dmem_rdata = 32'h1234;
    #1;
    total_cnt++; if (dmem_req !== 1'b0 || StallM !== 1'b0)
      $display("FAIL nm_req got req=%b stall=%b exp 0 0", dmem_req, StallM); else pass_cnt++;
    tick();
    total_cnt++; if (RD_W !== 5'd5 || ALU_ResultW !== 32'd7 || ReadDataW !== 32'd0 || RegWriteW !== 1'b1 || PCPlus4W !== 32'h1C)
      $display("FAIL nm_w got rd=%0d alu=%h rdata=%h rw=%b pc4=%h exp 5 7 0 1 1c", RD_W, ALU_ResultW, ReadDataW, RegWriteW, PCPlus4W); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_back_to_back();
    drive_load(32'h200, 5'd10, 1'b1, 32'h1111_2222);
    tick();
    total_cnt++; if (ReadDataW !== 32'h1111_2222 || RD_W !== 5'd10)
      $display("FAIL b2b_0 got rdata=%h rd=%0d exp 11112222 10", ReadDataW, RD_W); else pass_cnt++;
    drive_load(32'h20B & 32'hFFFF_FFFC, 5'd11, 1'b1, 32'h3333_4444);
    tick();
    total_cnt++; if (ReadDataW !== 32'h3333_4444 || RD_W !== 5'd11 || ALU_ResultW !== 32'h208)
      $display("FAIL b2b_1 got rdata=%h rd=%0d alu=%h exp 33334444 11 00000208", ReadDataW, RD_W, ALU_ResultW); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_timeout();
    drive_load(32'h300, 5'd4, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++; if (StallM !== 1'b1) $display("FAIL to_stall%0d got %b exp 1", i, StallM); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if (StallM !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL to_abort got stall=%b req=%b exp 0 0", StallM, dmem_req); else pass_cnt++;
    tick();
    total_cnt++; if (bus_err !== 1'b1 || RegWriteW !== 1'b0 || dbg_state_o !== 1'b0)
      $display("FAIL to_after got bus=%b rw=%b state=%b exp 1 0 0", bus_err, RegWriteW, dbg_state_o); else pass_cnt++;
    drive_load(32'h304, 5'd6, 1'b1, 32'h1234_5678);
    #1;
    total_cnt++; if (dmem_req !== 1'b1 || StallM !== 1'b0)
      $display("FAIL to_next_req got req=%b stall=%b exp 1 0", dmem_req, StallM); else pass_cnt++;
    tick();
    total_cnt++; if (ReadDataW !== 32'h1234_5678 || RegWriteW !== 1'b1 || bus_err !== 1'b1)
      $display("FAIL to_next_w got rdata=%h rw=%b bus=%b exp 12345678 1 1", ReadDataW, RegWriteW, bus_err); else pass_cnt++;
    drive_idle();
  endtask

  task automatic test_misalign();
    drive_load(32'h103, 5'd7, 1'b1, 32'hCAFE_F00D);
    #1;
    total_cnt++; if (dmem_req !== 1'b0 || StallM !== 1'b0)
      $display("FAIL mis_req got req=%b stall=%b exp 0 0", dmem_req, StallM); else pass_cnt++;
    tick();
    total_cnt++; if (misalign_err !== 1'b1 || RegWriteW !== 1'b0 || ReadDataW !== 32'd0 || RD_W !== 5'd0)
      $display("FAIL mis_w got mis=%b rw=%b rdata=%h rd=%0d exp 1 0 0 0", misalign_err, RegWriteW, ReadDataW, RD_W); else pass_cnt++;
    drive_idle();
    tick();
    total_cnt++; if (misalign_err !== 1'b1) $display("FAIL mis_sticky got %b exp 1", misalign_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    drive_load(32'h400, 5'd8, 1'b0, 32'h0);
    tick();
    total_cnt++; if (dbg_state_o !== 1'b1) $display("FAIL rmw_in_wait got %b exp 1", dbg_state_o); else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (dmem_req !== 1'b0 || StallM !== 1'b0 || dbg_state_o !== 1'b0)
      $display("FAIL rmw_comb got req=%b stall=%b state=%b exp 0 0 0", dmem_req, StallM, dbg_state_o); else pass_cnt++;
    total_cnt++; if (bus_err !== 1'b0 || misalign_err !== 1'b0 || RegWriteW !== 1'b0 || ReadDataW !== 32'd0 || ALU_ResultW !== 32'd0)
      $display("FAIL rmw_regs got bus=%b mis=%b rw=%b rdata=%h alu=%h exp all 0", bus_err, misalign_err, RegWriteW, ReadDataW, ALU_ResultW); else pass_cnt++;
    tick();
    rst = 1'b0;
    drive_idle();
    tick();
    total_cnt++; if (dbg_state_o !== 1'b0 || RegWriteW !== 1'b0 || dmem_req !== 1'b0)
      $display("FAIL rmw_after got state=%b rw=%b req=%b exp 0 0 0", dbg_state_o, RegWriteW, dmem_req); else pass_cnt++;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_non_mem();
    test_back_to_back();
    test_timeout();
    test_misalign();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
